// File: rtl/regfile_update_sched.sv
// Write scheduler for the 16x16 register file: CPU writeback decode plus
// nunchuck X/Y staging into r10/r11 behind a one-cycle register-file lock.

module regfile_en_lane #(
  parameter int IDX = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_we,
  input  logic [3:0] cpu_waddr,
  output logic       en
);
  localparam logic [3:0] IDX_L    = 4'(IDX);
  // r10/r11 belong to the sensor path; the CPU can never enable them
  localparam bit         WRITABLE = (IDX != 10) && (IDX != 11);

  always_ff @(posedge clk or negedge reset)
    if (!reset) en <= 1'b0;
    else        en <= WRITABLE && cpu_we && (cpu_waddr == IDX_L);
endmodule

module regfile_update_sched #(
  parameter int DW       = 16,
  parameter int MIN_GAP  = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic [3:0]    cpu_waddr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_hold,
  input  logic          sens_valid,
  input  logic [DW-1:0] sens_x,
  input  logic [DW-1:0] sens_y,
  output logic          sens_ready,
  output logic [15:0]   reg_en,
  output logic [DW-1:0] alu_bus,
  output logic [DW-1:0] new_10,
  output logic [DW-1:0] new_11,
  output logic          reg_lock,
  output logic          cpu_err,
  output logic          hold_to
);
  localparam int NUM_REGS = 16;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STAGE  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] GAP    = 2'd3;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [7:0] GAP_LAST  = 8'(MIN_GAP - 1);

  logic [1:0]    state;
  logic [DW-1:0] stage_x, stage_y;
  logic [7:0]    hold_cnt, gap_cnt;

  // CPU writeback path: one registered decode per register
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_lane
    regfile_en_lane #(.IDX(g)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .cpu_we    (cpu_we),
      .cpu_waddr (cpu_waddr),
      .en        (reg_en[g])
    );
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      alu_bus <= '0;
      cpu_err <= 1'b0;
    end else begin
      alu_bus <= cpu_wdata;
      cpu_err <= cpu_we && ((cpu_waddr == 4'd10) || (cpu_waddr == 4'd11));
    end

  assign sens_ready = (state == IDLE) && sens_valid;

  // reg_lock is registered so it drops only for the COMMIT cycle, glitch-free
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      stage_x  <= '0;
      stage_y  <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      new_10   <= '0;
      new_11   <= '0;
      reg_lock <= 1'b1;
      hold_to  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sens_valid) begin
          stage_x  <= sens_x;
          stage_y  <= sens_y;
          hold_cnt <= '0;
          state    <= STAGE;
        end
        STAGE: if (!cpu_hold || hold_cnt == HOLD_LAST) begin
          new_10   <= stage_x;
          new_11   <= stage_y;
          reg_lock <= 1'b0;
          if (cpu_hold) hold_to <= 1'b1;
          state    <= COMMIT;
        end else begin
          hold_cnt <= hold_cnt + 8'd1;
        end
        COMMIT: begin
          reg_lock <= 1'b1;
          gap_cnt  <= '0;
          state    <= GAP;
        end
        GAP: begin
          gap_cnt <= gap_cnt + 8'd1;
          if (gap_cnt == GAP_LAST) state <= IDLE;
        end
        default: begin
          reg_lock <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_regfile_update_sched.sv
// Directed bench for regfile_update_sched: CPU decode, sample staging,
// hold/timeout behaviour, sample pacing and mid-operation reset.

module tb_regfile_update_sched;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_we;
  logic [3:0]    cpu_waddr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_hold;
  logic          sens_valid;
  logic [DW-1:0] sens_x, sens_y;
  logic          sens_ready;
  logic [15:0]   reg_en;
  logic [DW-1:0] alu_bus, new_10, new_11;
  logic          reg_lock, cpu_err, hold_to;

  int checks = 0;
  int errors = 0;

  regfile_update_sched #(.DW(DW), .MIN_GAP(4), .MAX_HOLD(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_we     (cpu_we),
    .cpu_waddr  (cpu_waddr),
    .cpu_wdata  (cpu_wdata),
    .cpu_hold   (cpu_hold),
    .sens_valid (sens_valid),
    .sens_x     (sens_x),
    .sens_y     (sens_y),
    .sens_ready (sens_ready),
    .reg_en     (reg_en),
    .alu_bus    (alu_bus),
    .new_10     (new_10),
    .new_11     (new_11),
    .reg_lock   (reg_lock),
    .cpu_err    (cpu_err),
    .hold_to    (hold_to)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_we = 1'($urandom); cpu_waddr = 4'($urandom); cpu_wdata = 16'($urandom);
      cpu_hold = 1'($urandom); sens_valid = 1'($urandom);
      sens_x = 16'($urandom); sens_y = 16'($urandom);
      tick();
    end
    checks++;
    if (reg_en !== 16'h0 || alu_bus !== 16'h0 || new_10 !== 16'h0 || new_11 !== 16'h0 ||
        reg_lock !== 1'b1 || cpu_err !== 1'b0 || hold_to !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: reg_en=%h alu=%h n10=%h n11=%h lock=%b err=%b hto=%b",
               reg_en, alu_bus, new_10, new_11, reg_lock, cpu_err, hold_to);
    end
    cpu_we = 0; cpu_waddr = 0; cpu_wdata = 0; cpu_hold = 0; sens_valid = 0; sens_x = 0; sens_y = 0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (reg_en !== 16'h0 || reg_lock !== 1'b1) begin
        errors++;
        $display("FAIL reset_release: reg_en=%h lock=%b want 0000/1", reg_en, reg_lock);
      end
    end
  endtask

  task automatic test_cpu_write();
    cpu_we = 1; cpu_waddr = 4'd3; cpu_wdata = 16'hBEEF;
    tick();
    cpu_we = 0; cpu_wdata = 16'h0000;
    checks++;
    if (reg_en !== 16'h0008 || alu_bus !== 16'hBEEF || cpu_err !== 1'b0) begin
      errors++;
      $display("FAIL cpu_wr3: reg_en=%h alu=%h err=%b want 0008/BEEF/0", reg_en, alu_bus, cpu_err);
    end
    tick();
    checks++;
    if (reg_en !== 16'h0000 || alu_bus !== 16'h0000) begin
      errors++;
      $display("FAIL cpu_wr3_one_cycle: reg_en=%h alu=%h want 0000/0000", reg_en, alu_bus);
    end
    cpu_we = 1; cpu_waddr = 4'd10; cpu_wdata = 16'h1234;
    tick();
    cpu_we = 0;
    checks++;
    if (reg_en !== 16'h0000 || cpu_err !== 1'b1) begin
      errors++;
      $display("FAIL cpu_wr10: reg_en=%h err=%b want 0000/1", reg_en, cpu_err);
    end
    tick();
    checks++;
    if (cpu_err !== 1'b0) begin
      errors++;
      $display("FAIL cpu_err_pulse: err=%b want 0", cpu_err);
    end
    cpu_we = 1; cpu_waddr = 4'd11;
    tick();
    checks++;
    if (reg_en !== 16'h0000 || cpu_err !== 1'b1) begin
      errors++;
      $display("FAIL cpu_wr11: reg_en=%h err=%b want 0000/1", reg_en, cpu_err);
    end
    cpu_waddr = 4'd15; cpu_wdata = 16'h5A5A;
    tick();
    checks++;
    if (reg_en !== 16'h8000 || alu_bus !== 16'h5A5A || cpu_err !== 1'b0) begin
      errors++;
      $display("FAIL cpu_wr15: reg_en=%h alu=%h err=%b want 8000/5A5A/0", reg_en, alu_bus, cpu_err);
    end
    cpu_waddr = 4'd0;
    tick();
    cpu_we = 0;
    checks++;
    if (reg_en !== 16'h0001) begin
      errors++;
      $display("FAIL cpu_wr0: reg_en=%h want 0001", reg_en);
    end
    tick();
  endtask

  task automatic test_sample();
    sens_valid = 1; sens_x = 16'h0123; sens_y = 16'h0456;
    #1;
    checks++;
    if (sens_ready !== 1'b1) begin
      errors++;
      $display("FAIL sample_ready: got %b want 1", sens_ready);
    end
    tick();
    sens_valid = 0; sens_x = 16'hFFFF; sens_y = 16'hFFFF;
    checks++;
    if (reg_lock !== 1'b1 || new_10 !== 16'h0000) begin
      errors++;
      $display("FAIL sample_stage: lock=%b n10=%h want 1/0000", reg_lock, new_10);
    end
    tick();
    checks++;
    if (reg_lock !== 1'b0 || new_10 !== 16'h0123 || new_11 !== 16'h0456) begin
      errors++;
      $display("FAIL sample_commit: lock=%b n10=%h n11=%h want 0/0123/0456", reg_lock, new_10, new_11);
    end
    tick();
    checks++;
    if (reg_lock !== 1'b1 || new_10 !== 16'h0123 || new_11 !== 16'h0456) begin
      errors++;
      $display("FAIL sample_after: lock=%b n10=%h n11=%h want 1/0123/0456", reg_lock, new_10, new_11);
    end
    repeat (4) tick();
  endtask

  task automatic test_hold();
    cpu_hold = 1; sens_valid = 1; sens_x = 16'hAAAA; sens_y = 16'h5555;
    tick();
    sens_valid = 0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (reg_lock !== 1'b1) begin
        errors++;
        $display("FAIL hold_lock cyc %0d: lock=%b want 1", i, reg_lock);
      end
      tick();
    end
    cpu_hold = 0;
    checks++;
    if (reg_lock !== 1'b1 || new_10 !== 16'h0123) begin
      errors++;
      $display("FAIL hold_drop: lock=%b n10=%h want 1/0123", reg_lock, new_10);
    end
    tick();
    checks++;
    if (reg_lock !== 1'b0 || new_10 !== 16'hAAAA || new_11 !== 16'h5555 || hold_to !== 1'b0) begin
      errors++;
      $display("FAIL hold_commit: lock=%b n10=%h n11=%h hto=%b want 0/AAAA/5555/0",
               reg_lock, new_10, new_11, hold_to);
    end
    tick();
    repeat (4) tick();
  endtask

  task automatic test_hold_timeout();
    int lows;
    lows = 0;
    cpu_hold = 1; sens_valid = 1; sens_x = 16'hBBBB; sens_y = 16'hCCCC;
    tick();
    sens_valid = 0;
    for (int i = 0; i < 64; i++) begin
      if (reg_lock !== 1'b1) lows++;
      tick();
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL timeout_wait: lock low %0d cycles during STAGE, want 0", lows);
    end
    checks++;
    if (reg_lock !== 1'b0 || hold_to !== 1'b1 || new_10 !== 16'hBBBB || new_11 !== 16'hCCCC) begin
      errors++;
      $display("FAIL timeout_commit: lock=%b hto=%b n10=%h n11=%h want 0/1/BBBB/CCCC",
               reg_lock, hold_to, new_10, new_11);
    end
    tick();
    cpu_hold = 0;
    repeat (6) tick();
    checks++;
    if (hold_to !== 1'b1 || reg_lock !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: hto=%b lock=%b want 1/1", hold_to, reg_lock);
    end
  endtask

  task automatic test_back_to_back();
    sens_valid = 1; sens_x = 16'h1111; sens_y = 16'h2222;
    for (int t = 0; t < 22; t++) begin
      cpu_we = (t == 1); cpu_waddr = 4'd5; cpu_wdata = 16'h0F0F;
      #1;
      checks++;
      if (sens_ready !== ((t % 7) == 0)) begin
        errors++;
        $display("FAIL b2b_ready t=%0d: got %b want %b", t, sens_ready, (t % 7) == 0);
      end
      if (t == 2) begin
        checks++;
        if (reg_lock !== 1'b0 || reg_en !== 16'h0020 || new_10 !== 16'h1111) begin
          errors++;
          $display("FAIL b2b_concurrent: lock=%b reg_en=%h n10=%h want 0/0020/1111",
                   reg_lock, reg_en, new_10);
        end
      end
      tick();
    end
    cpu_we = 0; sens_valid = 0;
  endtask

  task automatic test_reset_mid();
    // cycle after the t=21 handshake: STAGE; next is COMMIT
    tick();
    checks++;
    if (reg_lock !== 1'b0) begin
      errors++;
      $display("FAIL mid_commit_reach: lock=%b want 0", reg_lock);
    end
    reset = 0;
    #1;
    checks++;
    if (reg_lock !== 1'b1 || new_10 !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_commit: lock=%b n10=%h want 1/0000", reg_lock, new_10);
    end
    tick();
    reset = 1;
    tick();
    sens_valid = 1; sens_x = 16'h7777; sens_y = 16'h8888;
    tick();
    sens_valid = 0;
    reset = 0;
    tick();
    reset = 1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (reg_lock !== 1'b1 || new_10 !== 16'h0000 || new_11 !== 16'h0000) begin
        errors++;
        $display("FAIL mid_reset_stage cyc %0d: lock=%b n10=%h n11=%h want 1/0000/0000",
                 i, reg_lock, new_10, new_11);
      end
      tick();
    end
  endtask

  initial begin
    reset = 0; cpu_we = 0; cpu_waddr = 0; cpu_wdata = 0; cpu_hold = 0;
    sens_valid = 0; sens_x = 0; sens_y = 0;
    test_reset();
    test_cpu_write();
    test_sample();
    test_hold();
    test_hold_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
